// File: rtl/nios_system_sysid_regbank.sv
// nios_system_sysid_regbank
//   Avalon-MM system-ID register bank. Word map:
//     0 ID (RO)          1 TIMESTAMP (RO)
//     2 UPTIME_LO (RO)   3 UPTIME_HI (RO, shadow captured by a word-2 read)
//     4 CTRL: bit0 CLEAR (write-1, self-clearing, reads 0), bit1 FREEZE (RW)
//     5.. SCRATCH words (RW, per-lane byteenable)
//   Reads are accepted every cycle and answered READ_LATENCY cycles later with
//   a one-cycle readdatavalid pulse; writes are accepted every cycle.
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   address        word address (ADDR_W bits)
//   read, write    access strobes (no waitrequest)
//   writedata      32-bit write data
//   byteenable     write byte lanes
//   readdata       read data, holds its last value while readdatavalid is low
//   readdatavalid  one pulse per accepted read, in request order
module nios_system_sysid_regbank #(
    parameter logic [31:0] SYSTEM_ID    = 32'h580B_3A79,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter int unsigned NUM_SCRATCH  = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [31:0] AddrId      = 32'd0;
    localparam logic [31:0] AddrStamp   = 32'd1;
    localparam logic [31:0] AddrUpLo    = 32'd2;
    localparam logic [31:0] AddrUpHi    = 32'd3;
    localparam logic [31:0] AddrCtrl    = 32'd4;
    localparam logic [31:0] AddrScratch = 32'd5;

    // Keep the scratch array non-empty so NUM_SCRATCH = 0 still elaborates.
    localparam int unsigned ScratchSlots = (NUM_SCRATCH == 0) ? 1 : NUM_SCRATCH;
    localparam int unsigned Depth        = (READ_LATENCY == 2) ? 2 : 1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("nios_system_sysid_regbank: READ_LATENCY must be 1 or 2");
    end
    if (NUM_SCRATCH > 3) begin : g_bad_scratch
        $error("nios_system_sysid_regbank: NUM_SCRATCH must be 0..3");
    end
    if ((5 + NUM_SCRATCH) > (1 << ADDR_W)) begin : g_bad_map
        $error("nios_system_sysid_regbank: register map exceeds 2**ADDR_W words");
    end

    logic [31:0] addr_w;
    assign addr_w = 32'(address);

    // State
    logic [63:0]                   uptime_q, uptime_d;
    logic [31:0]                   hi_shadow_q, hi_shadow_d;
    logic                          freeze_q, freeze_d;
    logic [ScratchSlots-1:0][31:0] scratch_q, scratch_d;
    logic [Depth-1:0]              pipe_vld_q, pipe_vld_d;
    logic [Depth-1:0][31:0]        pipe_data_q, pipe_data_d;

    logic        ctrl_wr;
    logic        clear;
    logic [31:0] rd_mux;

    assign ctrl_wr = write && (addr_w == AddrCtrl) && byteenable[0];
    assign clear   = ctrl_wr && writedata[0];

    // Read data is sampled from current state, so a same-cycle write or CLEAR
    // is not visible to the read.
    always_comb begin
        rd_mux = 32'h0;
        case (addr_w)
            AddrId:    rd_mux = SYSTEM_ID;
            AddrStamp: rd_mux = TIMESTAMP;
            AddrUpLo:  rd_mux = uptime_q[31:0];
            AddrUpHi:  rd_mux = hi_shadow_q;
            AddrCtrl:  rd_mux = {30'h0, freeze_q, 1'b0};
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr_w == AddrScratch + i) begin
                        rd_mux = scratch_q[i];
                    end
                end
            end
        endcase
    end

    // Uptime counter, FREEZE and the HI snapshot
    always_comb begin
        freeze_d    = freeze_q;
        hi_shadow_d = hi_shadow_q;
        if (ctrl_wr) begin
            freeze_d = writedata[1];
        end
        // CLEAR wins over both increment and the current FREEZE state.
        if (clear) begin
            uptime_d = 64'h0;
        end else if (freeze_q) begin
            uptime_d = uptime_q;
        end else begin
            uptime_d = uptime_q + 64'd1;
        end
        // Reading the low word freezes the matching high word for a later read.
        if (read && (addr_w == AddrUpLo)) begin
            hi_shadow_d = uptime_q[63:32];
        end
    end

    // Scratch writes, per byte lane
    always_comb begin
        scratch_d = scratch_q;
        if (write) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (addr_w == AddrScratch + i) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read pipeline. Data registers only load on a valid beat, so the final
    // stage holds the last returned word between pulses.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_data_d    = pipe_data_q;
        pipe_vld_d[0]  = read;
        if (read) begin
            pipe_data_d[0] = rd_mux;
        end
        for (int unsigned s = 1; s < Depth; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            if (pipe_vld_q[s-1]) begin
                pipe_data_d[s] = pipe_data_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q    <= 64'h0;
            hi_shadow_q <= 32'h0;
            freeze_q    <= 1'b0;
            scratch_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_data_q <= '0;
        end else begin
            uptime_q    <= uptime_d;
            hi_shadow_q <= hi_shadow_d;
            freeze_q    <= freeze_d;
            scratch_q   <= scratch_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    assign readdata      = pipe_data_q[Depth-1];
    assign readdatavalid = pipe_vld_q[Depth-1];

endmodule

// File: tb/tb_nios_system_sysid_regbank.sv
// Bench for nios_system_sysid_regbank: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=2 share every input, so each read checks both the
// returned data and the exact cycle of each readdatavalid pulse.
module tb_nios_system_sysid_regbank;

    localparam logic [31:0] SysId = 32'h580B_3A79;
    localparam logic [31:0] Stamp = 32'h6543_2100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata1, rdata2;
    logic        rvld1, rvld2;
    logic [63:0] preset;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    nios_system_sysid_regbank #(
        .TIMESTAMP    (Stamp),
        .READ_LATENCY (1)
    ) u_dut_l1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rdata1),
        .readdatavalid (rvld1)
    );

    nios_system_sysid_regbank #(
        .TIMESTAMP    (Stamp),
        .READ_LATENCY (2)
    ) u_dut_l2 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rdata2),
        .readdatavalid (rvld2)
    );

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One read; LAT=1 answers one edge after accept, LAT=2 exactly one later.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0;
        chk({name, " l1 vld"}, 32'(rvld1), 32'd1);
        chk({name, " l1 data"}, rdata1, exp);
        chk({name, " l2 early"}, 32'(rvld2), 32'd0);
        @(posedge clock);
        #1;
        chk({name, " l1 pulse"}, 32'(rvld1), 32'd0);
        chk({name, " l1 hold"}, rdata1, exp);
        chk({name, " l2 vld"}, 32'(rvld2), 32'd1);
        chk({name, " l2 data"}, rdata2, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        address    = a;
        write      = 1'b1;
        writedata  = d;
        byteenable = be;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    // Overrides the uptime counter in both instances for one edge, optionally
    // with a word-2 read accepted on that edge.
    task preset_uptime(input logic [63:0] v, input logic do_read);
        @(negedge clock);
        preset  = v;
        force u_dut_l1.uptime_q = preset;
        force u_dut_l2.uptime_q = preset;
        address = 3'd2;
        read    = do_read;
        @(posedge clock);
        #1;
        read = 1'b0;
        release u_dut_l1.uptime_q;
        release u_dut_l2.uptime_q;
    endtask

    initial begin
        logic [2:0]  b2b_addr [4];
        logic [31:0] b2b_exp  [4];

        reset_n    = 1'b0;
        address    = 3'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        preset     = 64'h0;

        vecs.push_back('{1'b0, 3'd0, 32'h0, 4'h0, SysId, "id"});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 4'h0, Stamp, "stamp"});
        vecs.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h0, "ctrl rst"});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 4'h0, 32'h0, "scr0 rst"});
        vecs.push_back('{1'b0, 3'd6, 32'h0, 4'h0, 32'h0, "scr1 rst"});
        vecs.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'h0, "unmapped"});
        vecs.push_back('{1'b1, 3'd5, 32'hDEAD_BEEF, 4'b0101, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 4'h0, 32'h00AD_00EF, "scr0 be0101"});
        vecs.push_back('{1'b1, 3'd1, 32'h0, 4'hF, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 4'h0, Stamp, "stamp ro"});
        vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 4'h0, SysId, "id ro"});
        vecs.push_back('{1'b1, 3'd6, 32'h1234_5678, 4'hF, 32'h0, ""});
        vecs.push_back('{1'b1, 3'd6, 32'hAABB_CCDD, 4'b1000, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd6, 32'h0, 4'h0, 32'hAA34_5678, "scr1 lane3"});
        vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'h0, "unmapped wr"});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 4'h0, 32'h00AD_00EF, "scr0 kept"});
        vecs.push_back('{1'b1, 3'd4, 32'h2, 4'b1110, 32'h0, ""});
        vecs.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h0, "ctrl lane0 off"});

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst l1 vld", 32'(rvld1), 32'd0);
        chk("rst l1 data", rdata1, 32'h0);
        chk("rst l2 vld", 32'(rvld2), 32'd0);
        chk("rst l2 data", rdata2, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
            end
        end

        // CLEAR+FREEZE in one access, then FREEZE holds the count
        wr(3'd4, 32'h3, 4'h1);
        rd(3'd4, 32'h2, "ctrl freeze");
        rd(3'd2, 32'h0, "frozen a");
        repeat (10) @(posedge clock);
        rd(3'd2, 32'h0, "frozen b");
        rd(3'd3, 32'h0, "frozen hi");
        // CLEAR and unfreeze: the count restarts from 0 on the commit edge
        wr(3'd4, 32'h1, 4'h1);
        rd(3'd2, 32'h0, "clear next");
        rd(3'd2, 32'h2, "count run");
        rd(3'd4, 32'h0, "ctrl unfrozen");

        // Snapshot: HI read returns the value captured with LO, not live HI
        preset_uptime(64'h0000_0001_FFFF_FFFF, 1'b1);
        chk("snap lo l1", rdata1, 32'hFFFF_FFFF);
        @(posedge clock);
        #1;
        chk("snap lo l2", rdata2, 32'hFFFF_FFFF);
        rd(3'd3, 32'h1, "snap hi");

        // Silent 64-bit wrap
        wr(3'd4, 32'h2, 4'h1);
        preset_uptime(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wr(3'd4, 32'h0, 4'h1);
        rd(3'd2, 32'hFFFF_FFFF, "wrap pre");
        rd(3'd2, 32'h1, "wrap post");
        rd(3'd3, 32'h0, "wrap hi");

        // Back-to-back reads, frozen at a known count
        wr(3'd4, 32'h2, 4'h1);
        preset_uptime(64'h0000_0005_0000_0123, 1'b0);
        b2b_addr[0] = 3'd0;  b2b_exp[0] = SysId;
        b2b_addr[1] = 3'd1;  b2b_exp[1] = Stamp;
        b2b_addr[2] = 3'd2;  b2b_exp[2] = 32'h0000_0123;
        b2b_addr[3] = 3'd7;  b2b_exp[3] = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            read = (k < 4);
            if (k < 4) begin
                address = b2b_addr[k];
            end
            @(posedge clock);
            #1;
            chk($sformatf("b2b%0d l1 vld", k), 32'(rvld1), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                chk($sformatf("b2b%0d l1 data", k), rdata1, b2b_exp[k]);
            end
            chk($sformatf("b2b%0d l2 vld", k), 32'(rvld2),
                (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 4) begin
                chk($sformatf("b2b%0d l2 data", k), rdata2, b2b_exp[k-1]);
            end
        end
        read = 1'b0;
        rd(3'd3, 32'h5, "b2b hi");

        // Read and write to the same word in one cycle returns the old value
        @(negedge clock);
        address    = 3'd5;
        read       = 1'b1;
        write      = 1'b1;
        writedata  = 32'h1111_1111;
        byteenable = 4'hF;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk("rw old l1", rdata1, 32'h00AD_00EF);
        @(posedge clock);
        #1;
        chk("rw old l2", rdata2, 32'h00AD_00EF);
        rd(3'd5, 32'h1111_1111, "rw new");

        // Reset with reads in flight
        @(negedge clock);
        address = 3'd0;
        read    = 1'b1;
        @(posedge clock);
        #1;
        address = 3'd1;
        @(posedge clock);
        #1;
        read = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("flush l1 vld", 32'(rvld1), 32'd0);
        chk("flush l1 data", rdata1, 32'h0);
        chk("flush l2 vld", 32'(rvld2), 32'd0);
        chk("flush l2 data", rdata2, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("no late %0d l1", k), 32'(rvld1), 32'd0);
            chk($sformatf("no late %0d l2", k), 32'(rvld2), 32'd0);
        end
        rd(3'd5, 32'h0, "scr0 after rst");
        rd(3'd4, 32'h0, "ctrl after rst");
        rd(3'd3, 32'h0, "hi after rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
